// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates load-use stalls, taken branches and
// data-memory waits into stage enables, with a sticky memory-timeout trap and stall/flush statistics.
module pipeline_stall_ctrl #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hz_stall,
  input  logic        branch_taken,
  input  logic        mem_busy,
  input  logic        cnt_clear,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        timeout_err,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEMWAIT     = 2'd1,
    TIMEOUT     = 2'd2,
    TIMEOUT_ALT = 2'd3
  } state_t;

  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [15:0] stall_cycles_r;
  logic [15:0] flush_count_r;
  logic        in_timeout_s;

  // Both TIMEOUT encodings share the MSB, so 2'd3 is trapped like 2'd2.
  assign in_timeout_s = state_r[1];

  // Stage enables decoded from the registered state and this cycle's requests.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    timeout_err = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_hold  = 1'b0;
      timeout_err = 1'b0;
    end else begin
      case (state_r)
        RUN, MEMWAIT: begin
          if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
          end else if (hz_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end else begin
            ifid_flush = 1'b0;
          end
        end
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_hold  = 1'b1;
          idex_bubble = 1'b1;
          ifid_flush  = 1'b0;
          timeout_err = 1'b1;
        end
      endcase
    end
  end

  // FSM and memory-wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_busy) begin
            state_r    <= MEMWAIT;
            wait_cnt_r <= 8'd1;
          end else begin
            state_r    <= RUN;
            wait_cnt_r <= wait_cnt_r;
          end
        end
        MEMWAIT: begin
          if (mem_busy) begin
            if (wait_cnt_r == WAIT_LAST) begin
              state_r    <= TIMEOUT;
              wait_cnt_r <= wait_cnt_r;
            end else begin
              state_r    <= MEMWAIT;
              wait_cnt_r <= wait_cnt_r + 8'd1;
            end
          end else begin
            state_r    <= RUN;
            wait_cnt_r <= 8'd0;
          end
        end
        default: begin
          // Timeout is a trap: only reset leaves it.
          state_r    <= state_r;
          wait_cnt_r <= wait_cnt_r;
        end
      endcase
    end
  end

  // Saturating statistics counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r <= 16'd0;
      flush_count_r  <= 16'd0;
    end else if (cnt_clear) begin
      stall_cycles_r <= 16'd0;
      flush_count_r  <= 16'd0;
    end else begin
      if (!pc_write && !in_timeout_s && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + 16'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (ifid_flush && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign state        = state_r;
  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;

endmodule
